req_arbiter_4: RTL and testbench

//   Registered 4-requester arbiter that shares one resource (bus/datapath slot).

---
 rtl/req_arbiter_4_if.sv | 13 +
 rtl/req_arbiter_4.sv | 113 +++++++++++
 tb/tb_req_arbiter_4.sv | 133 +++++++++++++
 3 files changed

// File: rtl/req_arbiter_4_if.sv
// Handshake bundle between the requesting blocks and the 4-way arbiter.
// The master drives mode/req, and the arbiter (slave) returns the grant.
interface req_arbiter_4_if;
    logic       mode;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    modport master (output mode, req, input gnt, gnt_id, gnt_valid, timeout);
    modport slave  (input mode, req, output gnt, gnt_id, gnt_valid, timeout);
endinterface

// File: rtl/req_arbiter_4.sv
// Registered 4-requester arbiter: fixed-priority or round-robin pick in IDLE,
// non-preemptive tenure with release handshake, optional hold timeout, one GAP cycle.
module req_arbiter_4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    req_arbiter_4_if.slave  arb
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t             state, state_nxt;
    logic [3:0]         gnt_q, gnt_nxt;
    logic [1:0]         id_q, id_nxt;
    logic               vld_q, vld_nxt;
    logic               to_q, to_nxt;
    logic [CNT_W-1:0]   hold_q, hold_nxt;
    logic [1:0]         rr_q, rr_nxt;
    logic [1:0]         win;
    logic               hold_max;

    // Winner pick. RR scans from rr_q upward; the lowest offset is assigned last so it wins.
    always_comb begin
        win = 2'd0;
        if (arb.mode) begin
            for (int i = 3; i >= 0; i--) begin
                if (arb.req[rr_q + 2'(i)]) win = rr_q + 2'(i);
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (arb.req[i]) win = 2'(i);
            end
        end
    end

    assign hold_max = (MAX_HOLD != 0) && (hold_q == CNT_W'(MAX_HOLD));

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_q;
        id_nxt    = id_q;
        vld_nxt   = vld_q;
        to_nxt    = 1'b0;
        hold_nxt  = hold_q;
        rr_nxt    = rr_q;
        case (state)
            IDLE: begin
                if (|arb.req) begin
                    state_nxt = GRANT;
                    gnt_nxt   = 4'b0001 << win;
                    id_nxt    = win;
                    vld_nxt   = 1'b1;
                    hold_nxt  = CNT_W'(1);
                    rr_nxt    = win + 2'd1;
                end
            end
            GRANT: begin
                // Release wins over timeout, so a simultaneous drop gives no pulse.
                if (!arb.req[id_q]) begin
                    state_nxt = GAP;
                    gnt_nxt   = 4'b0000;
                    vld_nxt   = 1'b0;
                    hold_nxt  = '0;
                end else if (hold_max) begin
                    state_nxt = GAP;
                    gnt_nxt   = 4'b0000;
                    vld_nxt   = 1'b0;
                    hold_nxt  = '0;
                    to_nxt    = 1'b1;
                end else begin
                    hold_nxt  = hold_q + CNT_W'(1);
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
                vld_nxt   = 1'b0;
                hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            gnt_q  <= 4'b0000;
            id_q   <= 2'd0;
            vld_q  <= 1'b0;
            to_q   <= 1'b0;
            hold_q <= '0;
            rr_q   <= 2'd0;
        end else begin
            state  <= state_nxt;
            gnt_q  <= gnt_nxt;
            id_q   <= id_nxt;
            vld_q  <= vld_nxt;
            to_q   <= to_nxt;
            hold_q <= hold_nxt;
            rr_q   <= rr_nxt;
        end
    end

    assign arb.gnt       = gnt_q;
    assign arb.gnt_id    = id_q;
    assign arb.gnt_valid = vld_q;
    assign arb.timeout   = to_q;

endmodule

// File: tb/tb_req_arbiter_4.sv
// Directed bench for req_arbiter_4: vector table for fixed/RR/no-preemption,
// hand sequences for reset, hold timeout, release-vs-timeout and async reset.
module tb_req_arbiter_4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    req_arbiter_4_if bus ();

    req_arbiter_4 #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       to;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [3:0] eg, input logic [1:0] eid, input logic eto);
        n_vec++;
        if (bus.gnt !== eg || bus.gnt_id !== eid || bus.gnt_valid !== (|eg) || bus.timeout !== eto) begin
            n_bad++;
            $display("FAIL %s: got gnt=%b id=%0d valid=%b timeout=%b, want gnt=%b id=%0d valid=%b timeout=%b",
                     name, bus.gnt, bus.gnt_id, bus.gnt_valid, bus.timeout, eg, eid, |eg, eto);
        end
    endtask

    task automatic step_chk(input string name, input logic [3:0] eg, input logic [1:0] eid, input logic eto);
        @(posedge clk);
        #1;
        chk(name, eg, eid, eto);
    endtask

    initial begin
        bus.mode = 1'b0;
        bus.req  = 4'b1111;

        // Reset held with all requests high: nothing may be granted.
        for (int i = 0; i < 3; i++) step_chk("reset_hold", 4'b0000, 2'd0, 1'b0);
        rst_n   = 1'b1;
        bus.req = 4'b0000;
        step_chk("post_reset_idle", 4'b0000, 2'd0, 1'b0);

        // Fixed priority, two tenures
        tbl.push_back('{1'b0, 4'b0011, 4'b0010, 2'd1, 1'b0});
        tbl.push_back('{1'b0, 4'b0011, 4'b0010, 2'd1, 1'b0});
        tbl.push_back('{1'b0, 4'b0001, 4'b0000, 2'd1, 1'b0});
        tbl.push_back('{1'b0, 4'b1001, 4'b0000, 2'd1, 1'b0});
        tbl.push_back('{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0});
        // Round-robin 0,1,2,3,0; each drops after 2 grant cycles
        tbl.push_back('{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b0});
        tbl.push_back('{1'b1, 4'b1110, 4'b0000, 2'd0, 1'b0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0010, 2'd1, 1'b0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0010, 2'd1, 1'b0});
        tbl.push_back('{1'b1, 4'b1101, 4'b0000, 2'd1, 1'b0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0000, 2'd1, 1'b0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0100, 2'd2, 1'b0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0100, 2'd2, 1'b0});
        tbl.push_back('{1'b1, 4'b1011, 4'b0000, 2'd2, 1'b0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0000, 2'd2, 1'b0});
        tbl.push_back('{1'b1, 4'b1111, 4'b1000, 2'd3, 1'b0});
        tbl.push_back('{1'b1, 4'b1111, 4'b1000, 2'd3, 1'b0});
        tbl.push_back('{1'b1, 4'b0111, 4'b0000, 2'd3, 1'b0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0000, 2'd3, 1'b0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b0});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0});
        // No preemption: req[3] rises while 0 holds the grant
        tbl.push_back('{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b0});
        tbl.push_back('{1'b0, 4'b1001, 4'b0001, 2'd0, 1'b0});
        tbl.push_back('{1'b0, 4'b1001, 4'b0001, 2'd0, 1'b0});
        tbl.push_back('{1'b0, 4'b1000, 4'b0000, 2'd0, 1'b0});
        tbl.push_back('{1'b0, 4'b1000, 4'b0000, 2'd0, 1'b0});
        tbl.push_back('{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0});

        foreach (tbl[i]) begin
            bus.mode = tbl[i].mode;
            bus.req  = tbl[i].req;
            step_chk($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].id, tbl[i].to);
        end

        // Hold timeout: 8 grant cycles, pulse in GAP, regrant after GAP+IDLE
        bus.mode = 1'b0;
        bus.req  = 4'b0100;
        for (int k = 1; k <= 8; k++) step_chk($sformatf("to_hold%0d", k), 4'b0100, 2'd2, 1'b0);
        step_chk("to_pulse", 4'b0000, 2'd2, 1'b1);
        step_chk("to_idle", 4'b0000, 2'd2, 1'b0);
        step_chk("to_regrant", 4'b0100, 2'd2, 1'b0);
        // Drop req in the very cycle the hold limit is reached: release, no pulse
        for (int k = 2; k <= 8; k++) step_chk($sformatf("rel_hold%0d", k), 4'b0100, 2'd2, 1'b0);
        bus.req = 4'b0000;
        step_chk("rel_over_timeout", 4'b0000, 2'd2, 1'b0);
        step_chk("rel_idle", 4'b0000, 2'd2, 1'b0);

        // Async reset mid-tenure; rr_ptr is 2 before reset, must return to 0
        bus.mode = 1'b1;
        bus.req  = 4'b0010;
        step_chk("pre_rst_grant", 4'b0010, 2'd1, 1'b0);
        step_chk("pre_rst_hold", 4'b0010, 2'd1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_drop", 4'b0000, 2'd0, 1'b0);
        step_chk("async_rst_held", 4'b0000, 2'd0, 1'b0);
        bus.req = 4'b0110;
        rst_n   = 1'b1;
        step_chk("post_rst_rr", 4'b0010, 2'd1, 1'b0);
        bus.req = 4'b0000;
        step_chk("post_rst_gap", 4'b0000, 2'd1, 1'b0);
        step_chk("post_rst_idle", 4'b0000, 2'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
